axis_mii_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one half-duplex MII TX MAC

---
 rtl/axis_mii_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axis_mii_tx_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mii_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one MII TX MAC between PORTS
// AXI-stream sources, attributing each frame's terminal MAC status to its sender.
module axis_mii_tx_arbiter #(
  parameter int PORTS          = 2,
  parameter int STATUS_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORTS-1:0]   enable,
  input  logic [8*PORTS-1:0] s_axis_data,
  input  logic [PORTS-1:0]   s_axis_valid,
  output logic [PORTS-1:0]   s_axis_ready,
  input  logic [PORTS-1:0]   s_axis_last,
  input  logic [PORTS-1:0]   s_axis_err,
  output logic [7:0]         m_axis_data,
  output logic               m_axis_valid,
  input  logic               m_axis_ready,
  output logic               m_axis_last,
  output logic               m_axis_err,
  input  logic               mac_transmit_ok,
  input  logic               mac_gave_up,
  input  logic               mac_late_collision,
  input  logic               mac_underflow,
  output logic [PORTS-1:0]   grant,
  output logic               done_valid,
  output logic [1:0]         done_port,
  output logic [2:0]         done_status
);

  localparam int              CW       = (STATUS_TIMEOUT > 0) ? $clog2(STATUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST  = CW'((STATUS_TIMEOUT > 0) ? STATUS_TIMEOUT - 1 : 0);
  localparam logic [1:0]      PTR_INIT = 2'(PORTS - 1);
  localparam logic [2:0]      ST_OK       = 3'd0;
  localparam logic [2:0]      ST_GAVE_UP  = 3'd1;
  localparam logic [2:0]      ST_LATE_COL = 3'd2;
  localparam logic [2:0]      ST_UNDERRUN = 3'd3;
  localparam logic [2:0]      ST_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_STATUS, REPORT} state_t;

  state_t            state_reg;
  logic [PORTS-1:0]  grant_reg;
  logic [1:0]        ptr_reg;
  logic [1:0]        sel_reg;
  logic              latched_reg;
  logic [2:0]        lstat_reg;
  logic [CW-1:0]     cnt_reg;
  logic              done_valid_reg;
  logic [1:0]        done_port_reg;
  logic [2:0]        done_status_reg;

  // Per-port signals padded to four lanes so the 2-bit select never indexes out of range.
  logic [7:0] data4 [4];
  logic [3:0] valid4;
  logic [3:0] last4;
  logic [3:0] err4;
  logic [3:0] cand4;
  logic [3:0] ready4;
  logic [3:0] pick_oh4;

  logic [1:0] pick_idx;
  logic       pick_found;
  logic [2:0] cand_idx;
  logic       status_pulse;
  logic [2:0] status_code;
  logic       send_last;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < PORTS) begin : g_real
        assign data4[gi]  = s_axis_data[8*gi +: 8];
        assign valid4[gi] = s_axis_valid[gi];
        assign last4[gi]  = s_axis_last[gi];
        assign err4[gi]   = s_axis_err[gi];
        assign cand4[gi]  = s_axis_valid[gi] & enable[gi];
      end else begin : g_unused
        assign data4[gi]  = 8'h00;
        assign valid4[gi] = 1'b0;
        assign last4[gi]  = 1'b0;
        assign err4[gi]   = 1'b0;
        assign cand4[gi]  = 1'b0;
      end
      assign pick_oh4[gi] = (pick_idx == 2'(gi));
      assign ready4[gi]   = (state_reg == SEND) && (sel_reg == 2'(gi)) && m_axis_ready;
    end
  endgenerate

  // Round-robin search starting one past the last winner.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand_idx   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand_idx = {1'b0, ptr_reg} + 3'(k);
      if (cand_idx >= 3'(PORTS)) cand_idx = cand_idx - 3'(PORTS);
      if (!pick_found && cand4[cand_idx[1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[1:0];
      end
    end
  end

  always_comb begin
    status_pulse = mac_transmit_ok | mac_gave_up | mac_late_collision | mac_underflow;
    if (mac_late_collision)  status_code = ST_LATE_COL;
    else if (mac_gave_up)    status_code = ST_GAVE_UP;
    else if (mac_underflow)  status_code = ST_UNDERRUN;
    else                     status_code = ST_OK;
  end

  assign m_axis_valid = (state_reg == SEND) && valid4[sel_reg];
  assign m_axis_data  = (state_reg == SEND) ? data4[sel_reg] : 8'h00;
  assign m_axis_last  = (state_reg == SEND) && last4[sel_reg];
  assign m_axis_err   = (state_reg == SEND) && err4[sel_reg];
  assign send_last    = m_axis_valid && m_axis_ready && m_axis_last;

  assign s_axis_ready = ready4[PORTS-1:0];
  assign grant        = grant_reg;
  assign done_valid   = done_valid_reg;
  assign done_port    = done_port_reg;
  assign done_status  = done_status_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      ptr_reg         <= PTR_INIT;
      sel_reg         <= '0;
      latched_reg     <= 1'b0;
      lstat_reg       <= '0;
      cnt_reg         <= '0;
      done_valid_reg  <= 1'b0;
      done_port_reg   <= '0;
      done_status_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_oh4[PORTS-1:0];
            ptr_reg   <= pick_idx;
            sel_reg   <= pick_idx;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // An early status (MAC draining after gave_up/underflow) is held until the last beat.
          if (status_pulse && !latched_reg) begin
            latched_reg <= 1'b1;
            lstat_reg   <= status_code;
          end
          if (send_last) begin
            if (latched_reg || status_pulse) begin
              state_reg       <= REPORT;
              done_valid_reg  <= 1'b1;
              done_port_reg   <= sel_reg;
              done_status_reg <= latched_reg ? lstat_reg : status_code;
            end else begin
              state_reg <= WAIT_STATUS;
              cnt_reg   <= '0;
            end
          end
        end
        WAIT_STATUS: begin
          if (status_pulse) begin
            state_reg       <= REPORT;
            done_valid_reg  <= 1'b1;
            done_port_reg   <= sel_reg;
            done_status_reg <= status_code;
          end else if (STATUS_TIMEOUT != 0 && cnt_reg == TO_LAST) begin
            state_reg       <= REPORT;
            done_valid_reg  <= 1'b1;
            done_port_reg   <= sel_reg;
            done_status_reg <= ST_TIMEOUT;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        REPORT: begin
          done_valid_reg <= 1'b0;
          grant_reg      <= '0;
          latched_reg    <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mii_tx_arbiter.sv
// Directed bench for axis_mii_tx_arbiter: a table of frame transactions plus
// hand-written sequences for idle-status filtering and mid-frame reset.
module tb_axis_mii_tx_arbiter;
  localparam int PORTS = 2;
  localparam int TO    = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PORTS-1:0]   enable = '0;
  logic [8*PORTS-1:0] s_axis_data = '0;
  logic [PORTS-1:0]   s_axis_valid = '0;
  logic [PORTS-1:0]   s_axis_ready;
  logic [PORTS-1:0]   s_axis_last = '0;
  logic [PORTS-1:0]   s_axis_err = '0;
  logic [7:0]         m_axis_data;
  logic               m_axis_valid;
  logic               m_axis_ready = 1'b0;
  logic               m_axis_last;
  logic               m_axis_err;
  logic               mac_transmit_ok = 1'b0;
  logic               mac_gave_up = 1'b0;
  logic               mac_late_collision = 1'b0;
  logic               mac_underflow = 1'b0;
  logic [PORTS-1:0]   grant;
  logic               done_valid;
  logic [1:0]         done_port;
  logic [2:0]         done_status;

  always #5 clk = ~clk;

  axis_mii_tx_arbiter #(.PORTS(PORTS), .STATUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last), .s_axis_err(s_axis_err),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last), .m_axis_err(m_axis_err),
    .mac_transmit_ok(mac_transmit_ok), .mac_gave_up(mac_gave_up),
    .mac_late_collision(mac_late_collision), .mac_underflow(mac_underflow),
    .grant(grant), .done_valid(done_valid), .done_port(done_port), .done_status(done_status)
  );

  // pulse bits: [0]=ok [1]=gave_up [2]=late_col [3]=underflow
  // pulse_beat<0 fires 'delay' cycles after the last beat, else while that beat is presented
  typedef struct {
    logic [1:0] en;
    logic [1:0] val;
    int         len;
    bit         stall;
    int         pulse_beat;
    int         delay;
    logic [3:0] pulse;
    bit         drop_en;
    int         exp_port;
    int         exp_status;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   beat[PORTS];
  int   cur_len = 1;
  int   frame_no = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pulse(input logic [3:0] p);
    mac_transmit_ok    = p[0];
    mac_gave_up        = p[1];
    mac_late_collision = p[2];
    mac_underflow      = p[3];
  endtask

  task automatic drive_src();
    for (int p = 0; p < PORTS; p++) begin
      s_axis_data[8*p +: 8] = {4'(p), 4'(beat[p])};
      s_axis_last[p]        = (beat[p] == cur_len - 1);
      s_axis_err[p]         = (beat[p] == 1);
    end
  endtask

  task automatic do_frame(input vec_t v);
    int n, k, c, exp_g;
    bit got_last, fired, hs;
    exp_g   = 1 << v.exp_port;
    cur_len = v.len;
    for (int p = 0; p < PORTS; p++) beat[p] = 0;
    drive_src();
    enable       = v.en;
    s_axis_valid = v.val;
    n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("grant", int'(grant), exp_g);
    chk("grant_latency", n, 1);

    k = 0; n = 0; got_last = 0; fired = 0;
    while (!got_last && n < 200) begin
      m_axis_ready = v.stall ? ((n % 2) == 0) : 1'b1;
      if (v.pulse != 0 && v.pulse_beat == k && !fired) begin
        set_pulse(v.pulse);
        fired = 1;
      end
      if (v.drop_en && k == 1) enable = '0;
      #1;
      chk("m_valid", int'(m_axis_valid), 1);
      chk("m_data", int'(m_axis_data), int'({4'(v.exp_port), 4'(k)}));
      chk("m_last", int'(m_axis_last), int'(k == v.len - 1));
      chk("m_err", int'(m_axis_err), int'(k == 1));
      chk("s_ready", int'(s_axis_ready), m_axis_ready ? exp_g : 0);
      chk("grant_hold", int'(grant), exp_g);
      hs = m_axis_ready;
      @(posedge clk);
      #1;
      set_pulse(4'b0000);
      if (hs) begin
        if (k == v.len - 1) begin
          got_last = 1;
          beat[v.exp_port] = 0;
        end else begin
          k++;
          beat[v.exp_port] = k;
        end
        drive_src();
      end
      n++;
    end
    chk("frame_end", int'(got_last), 1);
    m_axis_ready = 1'b1;

    c = 0;
    while (!done_valid && c < 100) begin
      if (c == 0) chk("wait_outputs", int'({m_axis_valid, s_axis_ready}), 0);
      if (v.pulse != 0 && v.pulse_beat < 0 && c == v.delay) set_pulse(v.pulse);
      tick();
      set_pulse(4'b0000);
      c++;
    end
    chk("done_latency", c, v.exp_lat);
    chk("done_valid", int'(done_valid), 1);
    chk("done_port", int'(done_port), v.exp_port);
    chk("done_status", int'(done_status), v.exp_status);
    $display("frame %0d: grant=%0d beats=%0d done_port=%0d done_status=%0d latency=%0d",
             frame_no, grant, v.len, done_port, done_status, c);
    frame_no++;
    tick();
    chk("done_single", int'(done_valid), 0);
    chk("grant_idle", int'(grant), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    //            en     val    len stl pb  dly pulse    drp port st lat
    vecs[0]  = '{2'b11, 2'b01, 3, 1'b0, -1, 5, 4'b0001, 1'b0, 0, 0, 6};
    vecs[1]  = '{2'b11, 2'b11, 2, 1'b1, -1, 1, 4'b0001, 1'b0, 1, 0, 2};
    vecs[2]  = '{2'b11, 2'b11, 2, 1'b0, -1, 1, 4'b0001, 1'b0, 0, 0, 2};
    vecs[3]  = '{2'b11, 2'b11, 2, 1'b0, -1, 1, 4'b0001, 1'b0, 1, 0, 2};
    vecs[4]  = '{2'b11, 2'b11, 2, 1'b0, -1, 1, 4'b0001, 1'b0, 0, 0, 2};
    vecs[5]  = '{2'b11, 2'b10, 6, 1'b0,  2, 0, 4'b0010, 1'b0, 1, 1, 0};
    vecs[6]  = '{2'b11, 2'b01, 1, 1'b0, -1, 2, 4'b0101, 1'b0, 0, 2, 3};
    vecs[7]  = '{2'b11, 2'b10, 2, 1'b0, -1, 0, 4'b0000, 1'b0, 1, 4, 16};
    vecs[8]  = '{2'b11, 2'b11, 2, 1'b0, -1, 0, 4'b1000, 1'b0, 0, 3, 1};
    vecs[9]  = '{2'b01, 2'b11, 3, 1'b0, -1, 0, 4'b1010, 1'b0, 0, 1, 1};
    vecs[10] = '{2'b10, 2'b10, 3, 1'b1,  1, 0, 4'b1000, 1'b1, 1, 3, 0};

    for (int p = 0; p < PORTS; p++) beat[p] = 0;
    repeat (2) tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_ready", int'(s_axis_ready), 0);
    chk("rst_m_valid", int'(m_axis_valid), 0);
    chk("rst_done", int'({done_valid, done_port, done_status}), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) do_frame(vecs[i]);

    // A status pulse while idle must not be attributed to the next frame.
    enable = '0;
    s_axis_valid = '0;
    set_pulse(4'b0001);
    tick();
    set_pulse(4'b0000);
    tick();
    hv = '{2'b11, 2'b01, 2, 1'b0, -1, 0, 4'b0000, 1'b0, 0, 4, 16};
    do_frame(hv);

    // Reset mid-frame: outputs clear at once, pointer returns to PORTS-1.
    cur_len = 4;
    for (int p = 0; p < PORTS; p++) beat[p] = 0;
    drive_src();
    enable = 2'b11;
    s_axis_valid = 2'b11;
    m_axis_ready = 1'b1;
    tick();
    tick();
    chk("pre_reset_grant", int'(grant), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_ready", int'(s_axis_ready), 0);
    chk("midrst_m_valid", int'(m_axis_valid), 0);
    chk("midrst_done", int'(done_valid), 0);
    $display("reset asserted mid-frame: grant=%0d m_valid=%0d", grant, m_axis_valid);
    tick();
    rst_n = 1'b1;
    enable = '0;
    s_axis_valid = '0;
    tick();
    hv = '{2'b10, 2'b11, 2, 1'b0, -1, 0, 4'b0001, 1'b0, 1, 0, 1};
    do_frame(hv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
